// File: rtl/pac_mover.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pac_mover: tick-driven Pac-Man motion FSM with wall probe and collision. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pac_mover #(
  parameter int         STEP    = 1,
  parameter int         SPRITE  = 32,
  parameter logic [9:0] START_X = 10'd32,
  parameter logic [8:0] START_Y = 9'd32,
  parameter int         X_MAX   = 608,
  parameter int         Y_MAX   = 448
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       tick,
  input  logic       dir_valid,
  input  logic [1:0] dir_req,
  input  logic [9:0] ghost_x,
  input  logic [8:0] ghost_y,
  output logic [9:0] probe_x,
  output logic [8:0] probe_y,
  input  logic       probe_wall,
  output logic [9:0] pac_x,
  output logic [8:0] pac_y,
  output logic [1:0] state,
  output logic       over,
  output logic       busy
);

  localparam logic [1:0] DIR_DOWN  = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [10:0] C_STEP_X  = 11'(STEP);
  localparam logic [9:0]  C_STEP_Y  = 10'(STEP);
  localparam logic [10:0] C_X_MAX   = 11'(X_MAX);
  localparam logic [9:0]  C_Y_MAX   = 10'(Y_MAX);
  localparam logic [9:0]  C_LEAD_X  = 10'(SPRITE + STEP - 1);
  localparam logic [8:0]  C_LEAD_Y  = 9'(SPRITE + STEP - 1);
  localparam logic [9:0]  C_FAR_X   = 10'(SPRITE - 1);
  localparam logic [8:0]  C_FAR_Y   = 9'(SPRITE - 1);
  localparam logic [9:0]  C_BACK_X  = 10'(STEP);
  localparam logic [8:0]  C_BACK_Y  = 9'(STEP);
  localparam logic [9:0]  C_HIT_X   = 10'(SPRITE);
  localparam logic [8:0]  C_HIT_Y   = 9'(SPRITE);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NA     = 3'd1,
    S_NB     = 3'd2,
    S_CA     = 3'd3,
    S_CB     = 3'd4,
    S_COMMIT = 3'd5
  } fsm_t;

  fsm_t       fsm_q, fsm_d;
  logic [9:0] pac_x_q, pac_x_d;
  logic [8:0] pac_y_q, pac_y_d;
  logic [1:0] head_q, head_d;
  logic       over_q, over_d;
  logic       pend_valid_q, pend_valid_d;
  logic [1:0] pend_dir_q, pend_dir_d;
  logic       blk_q, blk_d;
  logic       move_q, move_d;
  logic       move_pend_q, move_pend_d;
  logic [1:0] move_dir_q, move_dir_d;
  logic [9:0] new_x_q, new_x_d;
  logic [8:0] new_y_q, new_y_d;

  logic [1:0]  try_dir;
  logic [10:0] nx_w;
  logic [9:0]  ny_w;
  logic        in_bounds;
  logic [9:0]  c1x, c2x;
  logic [8:0]  c1y, c2y;
  logic        probing, second;
  logic        blocked;
  logic [9:0]  commit_x, dx;
  logic [8:0]  commit_y, dy;
  logic        hit;

  // Candidate position and leading-edge corners for the heading being tried.
  // Position math is one bit wider so bound violations show up as overflow.
  always_comb begin
    try_dir   = (fsm_q == S_NA || fsm_q == S_NB) ? pend_dir_q : head_q;
    nx_w      = {1'b0, pac_x_q};
    ny_w      = {1'b0, pac_y_q};
    in_bounds = 1'b0;
    c1x       = pac_x_q;
    c2x       = pac_x_q;
    c1y       = pac_y_q;
    c2y       = pac_y_q;
    case (try_dir)
      DIR_RIGHT: begin
        nx_w      = {1'b0, pac_x_q} + C_STEP_X;
        in_bounds = (nx_w <= C_X_MAX);
        c1x       = pac_x_q + C_LEAD_X;
        c2x       = pac_x_q + C_LEAD_X;
        c2y       = pac_y_q + C_FAR_Y;
      end
      DIR_LEFT: begin
        nx_w      = {1'b0, pac_x_q} - C_STEP_X;
        in_bounds = ({1'b0, pac_x_q} >= C_STEP_X);
        c1x       = pac_x_q - C_BACK_X;
        c2x       = pac_x_q - C_BACK_X;
        c2y       = pac_y_q + C_FAR_Y;
      end
      DIR_DOWN: begin
        ny_w      = {1'b0, pac_y_q} + C_STEP_Y;
        in_bounds = (ny_w <= C_Y_MAX);
        c1y       = pac_y_q + C_LEAD_Y;
        c2y       = pac_y_q + C_LEAD_Y;
        c2x       = pac_x_q + C_FAR_X;
      end
      default: begin
        ny_w      = {1'b0, pac_y_q} - C_STEP_Y;
        in_bounds = ({1'b0, pac_y_q} >= C_STEP_Y);
        c1y       = pac_y_q - C_BACK_Y;
        c2y       = pac_y_q - C_BACK_Y;
        c2x       = pac_x_q + C_FAR_X;
      end
    endcase
  end

  always_comb begin
    probing = (fsm_q == S_NA) || (fsm_q == S_NB) || (fsm_q == S_CA) || (fsm_q == S_CB);
    second  = (fsm_q == S_NB) || (fsm_q == S_CB);
    probe_x = '0;
    probe_y = '0;
    if (probing) begin
      probe_x = second ? c2x : c1x;
      probe_y = second ? c2y : c1y;
    end
    blocked = ~in_bounds | probe_wall;
  end

  always_comb begin
    commit_x = move_q ? new_x_q : pac_x_q;
    commit_y = move_q ? new_y_q : pac_y_q;
    dx       = (commit_x >= ghost_x) ? (commit_x - ghost_x) : (ghost_x - commit_x);
    dy       = (commit_y >= ghost_y) ? (commit_y - ghost_y) : (ghost_y - commit_y);
    hit      = (dx < C_HIT_X) && (dy < C_HIT_Y);
  end

  always_comb begin
    fsm_d        = fsm_q;
    pac_x_d      = pac_x_q;
    pac_y_d      = pac_y_q;
    head_d       = head_q;
    over_d       = over_q;
    pend_valid_d = pend_valid_q;
    pend_dir_d   = pend_dir_q;
    blk_d        = blk_q;
    move_d       = move_q;
    move_pend_d  = move_pend_q;
    move_dir_d   = move_dir_q;
    new_x_d      = new_x_q;
    new_y_d      = new_y_q;

    case (fsm_q)
      S_IDLE: begin
        if (tick && !over_q) begin
          fsm_d  = (pend_valid_q || dir_valid) ? S_NA : S_CA;
          blk_d  = 1'b0;
          move_d = 1'b0;
        end
      end
      // Both pending corners are always sampled so the fallback latency is fixed.
      S_NA: begin
        blk_d = blocked;
        fsm_d = S_NB;
      end
      S_NB: begin
        if (blk_q || blocked) begin
          fsm_d = S_CA;
        end else begin
          move_d      = 1'b1;
          move_pend_d = 1'b1;
          move_dir_d  = pend_dir_q;
          new_x_d     = nx_w[9:0];
          new_y_d     = ny_w[8:0];
          fsm_d       = S_COMMIT;
        end
      end
      S_CA: begin
        if (blocked) begin
          move_d = 1'b0;
          fsm_d  = S_COMMIT;
        end else begin
          fsm_d = S_CB;
        end
      end
      S_CB: begin
        if (blocked) begin
          move_d = 1'b0;
        end else begin
          move_d      = 1'b1;
          move_pend_d = 1'b0;
          move_dir_d  = head_q;
          new_x_d     = nx_w[9:0];
          new_y_d     = ny_w[8:0];
        end
        fsm_d = S_COMMIT;
      end
      S_COMMIT: begin
        pac_x_d = commit_x;
        pac_y_d = commit_y;
        if (move_q) begin
          head_d = move_dir_q;
          if (move_pend_q) begin
            pend_valid_d = 1'b0;
          end
        end
        if (hit) begin
          over_d = 1'b1;
        end
        fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase

    // A fresh request always wins over the clear issued by a pending move.
    if (dir_valid) begin
      pend_valid_d = 1'b1;
      pend_dir_d   = dir_req;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      fsm_q        <= S_IDLE;
      pac_x_q      <= START_X;
      pac_y_q      <= START_Y;
      head_q       <= DIR_RIGHT;
      over_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_dir_q   <= DIR_DOWN;
      blk_q        <= 1'b0;
      move_q       <= 1'b0;
      move_pend_q  <= 1'b0;
      move_dir_q   <= DIR_RIGHT;
      new_x_q      <= START_X;
      new_y_q      <= START_Y;
    end else begin
      fsm_q        <= fsm_d;
      pac_x_q      <= pac_x_d;
      pac_y_q      <= pac_y_d;
      head_q       <= head_d;
      over_q       <= over_d;
      pend_valid_q <= pend_valid_d;
      pend_dir_q   <= pend_dir_d;
      blk_q        <= blk_d;
      move_q       <= move_d;
      move_pend_q  <= move_pend_d;
      move_dir_q   <= move_dir_d;
      new_x_q      <= new_x_d;
      new_y_q      <= new_y_d;
    end
  end

  assign pac_x = pac_x_q;
  assign pac_y = pac_y_q;
  assign state = head_q;
  assign over  = over_q;
  assign busy  = (fsm_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pac_mover.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pac_mover: scoreboard bench for pac_mover moves, bounds and collision. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_pac_mover;

  logic       clk = 1'b0;
  logic       clrn;
  logic       tick;
  logic       dir_valid;
  logic [1:0] dir_req;
  logic [9:0] ghost_x;
  logic [8:0] ghost_y;
  logic [9:0] probe_x;
  logic [8:0] probe_y;
  logic       probe_wall;
  logic [9:0] pac_x;
  logic [8:0] pac_y;
  logic [1:0] state;
  logic       over;
  logic       busy;

  pac_mover dut (
    .clk        (clk),
    .clrn       (clrn),
    .tick       (tick),
    .dir_valid  (dir_valid),
    .dir_req    (dir_req),
    .ghost_x    (ghost_x),
    .ghost_y    (ghost_y),
    .probe_x    (probe_x),
    .probe_y    (probe_y),
    .probe_wall (probe_wall),
    .pac_x      (pac_x),
    .pac_y      (pac_y),
    .state      (state),
    .over       (over),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int st;
    int ov;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   tick_edge   = 0;
  int   wall_mode   = 0;
  logic busy_prev   = 1'b0;

  // Wall map: 0 none, 1 a horizontal wall on row 64, otherwise solid.
  always_comb begin
    case (wall_mode)
      0:       probe_wall = 1'b0;
      1:       probe_wall = (probe_y == 9'd64);
      default: probe_wall = 1'b1;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Each completed move (busy falling) retires the oldest expectation.
  always @(negedge clk) begin
    if (busy_prev && !busy && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("pac_x", 32'(pac_x), e.x);
      check("pac_y", 32'(pac_y), e.y);
      check("state", 32'(state), e.st);
      check("over", 32'(over), e.ov);
      if (e.lat > 0) check("latency", cyc - tick_edge + 1, e.lat);
    end
    busy_prev = busy;
  end

  task automatic do_tick(input logic dv, input logic [1:0] dd, input int ex, input int ey,
                         input int es, input int eo, input int lat);
    exp_t e;
    @(negedge clk);
    tick      = 1'b1;
    dir_valid = dv;
    dir_req   = dd;
    e.x = ex; e.y = ey; e.st = es; e.ov = eo; e.lat = lat;
    sb.push_back(e);
    tick_edge = cyc + 1;
    @(negedge clk);
    tick      = 1'b0;
    dir_valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      check("move_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic set_dir(input logic [1:0] d);
    @(negedge clk);
    dir_valid = 1'b1;
    dir_req   = d;
    @(negedge clk);
    dir_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clrn = 1'b0; tick = 1'b0; dir_valid = 1'b0; dir_req = 2'b00;
    ghost_x = 10'd600; ghost_y = 9'd400;
    repeat (2) @(negedge clk);
    check("rst_x", 32'(pac_x), 32);
    check("rst_y", 32'(pac_y), 32);
    check("rst_state", 32'(state), 2);
    check("rst_over", 32'(over), 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge clk);
    clrn = 1'b1;

    do_tick(1'b0, 2'b00, 33, 32, 2, 0, 4);
    do_tick(1'b0, 2'b00, 34, 32, 2, 0, 4);
    do_tick(1'b0, 2'b00, 35, 32, 2, 0, 4);

    // Pending down blocked by the row-64 wall: falls back to right.
    set_dir(2'b00);
    wall_mode = 1;
    do_tick(1'b0, 2'b00, 36, 32, 2, 0, 6);
    wall_mode = 0;
    do_tick(1'b0, 2'b00, 36, 33, 0, 0, 4);
    do_tick(1'b0, 2'b00, 36, 34, 0, 0, 4);
    do_tick(1'b1, 2'b11, 35, 34, 3, 0, 4);
    do_tick(1'b0, 2'b00, 34, 34, 3, 0, 4);

    wall_mode = 2;
    do_tick(1'b0, 2'b00, 34, 34, 3, 0, 0);
    wall_mode = 0;

    set_dir(2'b01);
    do_tick(1'b0, 2'b00, 34, 33, 1, 0, 4);
    for (int y = 32; y >= 0; y--) do_tick(1'b0, 2'b00, 34, y, 1, 0, 4);
    do_tick(1'b0, 2'b00, 34, 0, 1, 0, 0);

    set_dir(2'b10);
    for (int x = 35; x <= 608; x++) do_tick(1'b0, 2'b00, x, 0, 2, 0, 4);
    do_tick(1'b0, 2'b00, 608, 0, 2, 0, 0);
    wall_mode = 2;
    do_tick(1'b0, 2'b00, 608, 0, 2, 0, 0);
    wall_mode = 0;

    // Asynchronous reset while the FSM sits in NB.
    @(negedge clk);
    tick = 1'b1; dir_valid = 1'b1; dir_req = 2'b11;
    @(negedge clk);
    tick = 1'b0; dir_valid = 1'b0;
    @(negedge clk);
    check("busy_in_nb", 32'(busy), 1);
    clrn = 1'b0;
    #1;
    check("mid_rst_x", 32'(pac_x), 32);
    check("mid_rst_y", 32'(pac_y), 32);
    check("mid_rst_state", 32'(state), 2);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_over", 32'(over), 0);
    @(negedge clk);
    ghost_x = 10'd60; ghost_y = 9'd32;
    clrn = 1'b1;

    do_tick(1'b0, 2'b00, 33, 32, 2, 1, 4);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("busy_after_over", 32'(busy), 0);
    end
    check("frozen_x", 32'(pac_x), 33);
    check("over_sticky", 32'(over), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
